axil_master_bridge: RTL and testbench

Converts the CPU core's native valid/ready memory requests into single AXI-Lite master transactions that drive the slave port of the peripheral subsystem (interconnect to UART and GPIO). It issues exactly one outstanding read or write at a time. It returns read data and response status to the core through a one-cycle completion pulse.

---
 rtl/axil_master_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_bridge.sv
// Bridges the core's valid/ready memory port onto a single-outstanding AXI-Lite master.
// Each request is latched on acceptance and completes with a one-cycle mem_ready pulse.
module axil_master_bridge #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_err,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                  state_r, state_s;
    logic                    aw_done_r, aw_done_s;
    logic                    w_done_r, w_done_s;
    logic                    awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s;
    logic                    mem_ready_s, mem_err_s;
    logic [DATA_WIDTH-1:0]   mem_rdata_s, wdata_s;
    logic [STRB_WIDTH-1:0]   wstrb_s;
    logic [ADDR_WIDTH-1:0]   awaddr_s, araddr_s, word_addr_s;

    assign awprot = 3'b000;
    assign arprot = 3'b000;
    // Byte lanes are selected by wstrb alone, so the bus address is word aligned.
    assign word_addr_s = mem_addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output decode; every output holds unless a transition updates it.
    always_comb begin
        state_s     = state_r;
        aw_done_s   = aw_done_r;
        w_done_s    = w_done_r;
        awvalid_s   = awvalid;
        wvalid_s    = wvalid;
        bready_s    = bready;
        arvalid_s   = arvalid;
        rready_s    = rready;
        mem_ready_s = 1'b0;
        mem_err_s   = mem_err;
        mem_rdata_s = mem_rdata;
        awaddr_s    = awaddr;
        araddr_s    = araddr;
        wdata_s     = wdata;
        wstrb_s     = wstrb;
        case (state_r)
            IDLE: begin
                if (mem_valid) begin
                    mem_err_s = 1'b0;
                    if (mem_wstrb != {STRB_WIDTH{1'b0}}) begin
                        awaddr_s  = word_addr_s;
                        wdata_s   = mem_wdata;
                        wstrb_s   = mem_wstrb;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        aw_done_s = 1'b0;
                        w_done_s  = 1'b0;
                        state_s   = WRITE;
                    end else begin
                        araddr_s  = word_addr_s;
                        arvalid_s = 1'b1;
                        state_s   = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (awvalid && awready) begin
                    awvalid_s = 1'b0;
                    aw_done_s = 1'b1;
                end else begin
                    awvalid_s = awvalid;
                end
                if (wvalid && wready) begin
                    wvalid_s = 1'b0;
                    w_done_s = 1'b1;
                end else begin
                    wvalid_s = wvalid;
                end
                if (aw_done_s && w_done_s) begin
                    bready_s = 1'b1;
                    state_s  = WRESP;
                end else begin
                    state_s = WRITE;
                end
            end
            WRESP: begin
                if (bvalid && bready) begin
                    mem_err_s   = (bresp > 2'b01);
                    bready_s    = 1'b0;
                    mem_ready_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    state_s = WRESP;
                end
            end
            READ: begin
                if (arvalid && arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = RDATA;
                end else begin
                    state_s = READ;
                end
            end
            RDATA: begin
                if (rvalid && rready) begin
                    mem_rdata_s = rdata;
                    mem_err_s   = (rresp > 2'b01);
                    rready_s    = 1'b0;
                    mem_ready_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    state_s = RDATA;
                end
            end
            DONE: begin
                // The core still holds mem_valid here, so it must not be sampled.
                state_s = IDLE;
            end
            default: begin
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                bready_s  = 1'b0;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // Output and transaction-tracking registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= {DATA_WIDTH{1'b0}};
            awaddr    <= {ADDR_WIDTH{1'b0}};
            araddr    <= {ADDR_WIDTH{1'b0}};
            wdata     <= {DATA_WIDTH{1'b0}};
            wstrb     <= {STRB_WIDTH{1'b0}};
        end else begin
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
            awvalid   <= awvalid_s;
            wvalid    <= wvalid_s;
            bready    <= bready_s;
            arvalid   <= arvalid_s;
            rready    <= rready_s;
            mem_ready <= mem_ready_s;
            mem_err   <= mem_err_s;
            mem_rdata <= mem_rdata_s;
            awaddr    <= awaddr_s;
            araddr    <= araddr_s;
            wdata     <= wdata_s;
            wstrb     <= wstrb_s;
        end
    end
endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: a cycle-level AXI-Lite slave model with configurable stalls
// and a transaction-level model of the expected bus payloads and core-side completion.
module tb_axil_master_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, mem_err;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [23:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    axil_master_bridge #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_addr = 24'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err} !== 7'b0) begin
            errors++;
            $display("FAIL %s ctrl got=%b exp=0000000", name,
                     {awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err});
        end
        checks++;
        if ({mem_rdata, awaddr, araddr, wdata, wstrb, awprot, arprot} !== 122'h0) begin
            errors++;
            $display("FAIL %s data got rdata=%h aw=%h ar=%h wd=%h ws=%h exp all zero", name,
                     mem_rdata, awaddr, araddr, wdata, wstrb);
        end
    endtask

    // One core request against the slave model; delays count cycles of valid/ready before the
    // slave responds. exp_lat > 0 requires mem_ready exactly that many cycles after acceptance.
    task automatic run_txn(input string name, input logic [23:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int awd, input int wd, input int bd,
                           input int ard, input int rd, input logic [1:0] resp,
                           input logic [31:0] rdat, input int exp_lat);
        logic        is_wr = (s != 4'h0);
        logic [23:0] ea = (a / 24'd4) * 24'd4;
        logic aw_d = 0, w_d = 0, ar_d = 0, done = 0, fin;
        logic pawv = 0, pwv = 0, pbr = 0, parv = 0, prr = 0;
        int awc = 0, wc = 0, bc = 0, arc = 0, rc = 0;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        for (int c = 1; c <= 200 && !done; c++) begin
            tick();
            if (c == 1) begin
                mem_addr = 24'($urandom); mem_wdata = $urandom; mem_wstrb = 4'($urandom);
                checks++;
                if (mem_err !== 1'b0) begin
                    errors++; $display("FAIL %s err_clear got=%b exp=0", name, mem_err);
                end
                checks++;
                if ({awvalid, wvalid, arvalid} !== (is_wr ? 3'b110 : 3'b001)) begin
                    errors++;
                    $display("FAIL %s launch got=%b exp=%b", name, {awvalid, wvalid, arvalid},
                             is_wr ? 3'b110 : 3'b001);
                end
            end
            fin = 1'b0;
            if (pawv && awready) aw_d = 1'b1;
            if (pwv && wready) w_d = 1'b1;
            if (pbr && bvalid) fin = 1'b1;
            if (parv && arready) ar_d = 1'b1;
            if (prr && rvalid) fin = 1'b1;
            if (fin && !is_wr) exp_rdata = rdat;
            checks++;
            if (mem_ready !== fin) begin
                errors++; $display("FAIL %s mem_ready c=%0d got=%b exp=%b", name, c, mem_ready, fin);
            end
            if (fin) begin
                done = 1'b1;
                checks++;
                if ({mem_err, mem_rdata} !== {resp[1], exp_rdata}) begin
                    errors++;
                    $display("FAIL %s completion got err=%b rdata=%h exp err=%b rdata=%h",
                             name, mem_err, mem_rdata, resp[1], exp_rdata);
                end
                if (exp_lat > 0) begin
                    checks++;
                    if (c != exp_lat) begin
                        errors++; $display("FAIL %s latency got=%0d exp=%0d", name, c, exp_lat);
                    end
                end
            end
            if (awvalid) begin
                checks++;
                if ({aw_d, awprot, awaddr} !== {1'b0, 3'b000, ea}) begin
                    errors++;
                    $display("FAIL %s aw got done=%b prot=%h addr=%h exp 0/0/%h", name, aw_d,
                             awprot, awaddr, ea);
                end
            end
            if (wvalid) begin
                checks++;
                if ({w_d, wdata, wstrb} !== {1'b0, d, s}) begin
                    errors++;
                    $display("FAIL %s w got done=%b data=%h strb=%h exp 0/%h/%h", name, w_d,
                             wdata, wstrb, d, s);
                end
            end
            if (bready) begin
                checks++;
                if ({aw_d, w_d} !== 2'b11) begin
                    errors++; $display("FAIL %s bready_early got aw/w=%b exp=11", name, {aw_d, w_d});
                end
            end
            if (arvalid) begin
                checks++;
                if ({ar_d, arprot, araddr} !== {1'b0, 3'b000, ea}) begin
                    errors++;
                    $display("FAIL %s ar got done=%b prot=%h addr=%h exp 0/0/%h", name, ar_d,
                             arprot, araddr, ea);
                end
            end
            if (rready) begin
                checks++;
                if (ar_d !== 1'b1) begin
                    errors++; $display("FAIL %s rready_early got ar_done=%b exp=1", name, ar_d);
                end
            end
            if (awvalid) awc++;
            if (wvalid) wc++;
            if (bready) bc++;
            if (arvalid) arc++;
            if (rready) rc++;
            awready = awvalid && (awc > awd);
            wready  = wvalid && (wc > wd);
            bvalid  = bready && (bc > bd);
            bresp   = bvalid ? resp : 2'b00;
            arready = arvalid && (arc > ard);
            rvalid  = rready && (rc > rd);
            rresp   = rvalid ? resp : 2'b00;
            rdata   = rvalid ? rdat : $urandom;
            pawv = awvalid; pwv = wvalid; pbr = bready; parv = arvalid; prr = rready;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout got=no mem_ready exp=mem_ready", name);
        end
        tick();
        checks++;
        if ({mem_ready, awvalid, wvalid, arvalid, bready, rready} !== 6'b0) begin
            errors++;
            $display("FAIL %s after_done got=%b exp=000000", name,
                     {mem_ready, awvalid, wvalid, arvalid, bready, rready});
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        exp_rdata = 32'h0;
        tick(); tick();
        check_reset_values("reset");
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_fast();
        run_txn("write_fast", 24'h010004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3);
        run_txn("read_fast", 24'h010008, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h12345678, 3);
    endtask

    task automatic test_read_stall();
        run_txn("read_stall", 24'h02000A, 32'h0, 4'h0, 0, 0, 0, 5, 2, 2'b00, 32'h00000041, -1);
        run_txn("write_keeps_rdata", 24'h000010, 32'hA5A5A5A5, 4'h3, 1, 2, 1, 0, 0, 2'b00,
                32'h0, -1);
    endtask

    task automatic test_skew();
        run_txn("skew_w_first", 24'h000020, 32'h0BADF00D, 4'hF, 3, 0, 0, 0, 0, 2'b00, 32'h0, -1);
        run_txn("skew_aw_first", 24'h000024, 32'h01020304, 4'hC, 0, 4, 2, 0, 0, 2'b00, 32'h0, -1);
    endtask

    task automatic test_errors();
        run_txn("write_decerr", 24'h0F0000, 32'h11111111, 4'hF, 0, 0, 1, 0, 0, 2'b11, 32'h0, -1);
        run_txn("read_slverr", 24'h0F0004, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b10, 32'hCAFE0001, -1);
        run_txn("okay_after_err", 24'h000030, 32'h22222222, 4'h1, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3);
    endtask

    task automatic test_unaligned();
        run_txn("unaligned", 24'h000003, 32'h77000000, 4'b1000, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3);
    endtask

    task automatic test_reset_mid_read();
        mem_valid = 1'b1; mem_addr = 24'h000040; mem_wstrb = 4'h0;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            errors++; $display("FAIL rst_mid rready got=%b exp=1", rready);
        end
        rvalid = 1'b1; rdata = 32'h99999999;
        rst = 1'b0;
        #1;
        exp_rdata = 32'h0;
        check_reset_values("rst_mid");
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_ready !== 1'b0) begin
                errors++; $display("FAIL rst_mid no_ready got=%b exp=0", mem_ready);
            end
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        run_txn("read_after_rst", 24'h000044, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h5A5A0042, 3);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 24; i++) begin
            logic [3:0] s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) s = 4'h0;
            run_txn("random", 24'($urandom), $urandom, s, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 2'($urandom), $urandom, -1);
        end
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_read_stall();
        test_skew();
        test_errors();
        test_unaligned();
        test_reset_mid_read();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
